dm_sized_mem: RTL

Parametrised, handshaked data memory for the MIPS CPU load/store path. It supports byte, halfword and word accesses, with signed or unsigned load extension. Sub-word stores are true byte-lane writes: the other bytes of the word are left unchanged. Misaligned accesses are reported as errors, and the RAM is cleared by a sweep after every reset. It sits between the MEM stage and the data RAM banks.

---
 rtl/dm_pkg.sv | 48 ++++
 rtl/dm_bank.sv | 29 ++
 rtl/dm_sized_mem.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the sized data memory: access-size codes,
// FSM state type, and the byte-lane decode helpers used by the top level.
package dm_pkg;

  localparam logic [1:0] DM_BYTE  = 2'd0;
  localparam logic [1:0] DM_HALF  = 2'd1;
  localparam logic [1:0] DM_WORD  = 2'd2;
  localparam logic [1:0] DM_DWORD = 2'd3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dm_state_t;

  // Byte-enable mask: (1<<size) consecutive lanes starting at lane 'off',
  // clipped to the number of lanes actually present in the word.
  function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                           input logic [2:0] off,
                                           input int         lanes);
    logic [15:0] base;
    logic [15:0] lim;
    logic [15:0] m;
    case (size)
      DM_BYTE: base = 16'h0001;
      DM_HALF: base = 16'h0003;
      DM_WORD: base = 16'h000F;
      default: base = 16'h00FF;
    endcase
    lim = 16'((32'd1 << lanes) - 32'd1);
    m   = (base << off) & lim;
    return m[7:0];
  endfunction

  // Natural-alignment check; a dword on a 32-bit memory is always illegal.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] off,
                                         input int         data_w);
    logic bad;
    case (size)
      DM_BYTE: bad = 1'b0;
      DM_HALF: bad = off[0];
      DM_WORD: bad = (off[1:0] != 2'b00);
      default: bad = (data_w == 32) || (off != 3'b000);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_bank.sv
// One byte lane of the data RAM: synchronous write, synchronous read with
// a read enable so the read register holds while the response is stalled.
module dm_bank #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rdata_q;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  // Registered read port; returns the contents before a same-edge write.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_sized_mem.sv
// Handshaked byte/half/word/dword data memory for the load/store path.
// Clears itself with a sweep after reset, then serves one request per
// cycle through a request stage (bank read) and a response register.
module dm_sized_mem
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam int WI_W  = ADDR_W - LB;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  dm_state_t         state_q;
  logic [WI_W-1:0]   ic_q;
  logic              init_done_q;

  logic              pendValid_q, pendValid_d;
  logic              pendWe_q, pendWe_d;
  logic              pendErr_q, pendErr_d;
  logic [1:0]        pendSize_q, pendSize_d;
  logic              pendSigned_q, pendSigned_d;
  logic [LB-1:0]     pendOff_q, pendOff_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [WI_W-1:0]   wordIdx;
  logic [LB-1:0]     off;
  logic [2:0]        offExt;
  logic [LANES-1:0]  laneMask;
  logic              reqErr;
  logic              accept;
  logic              advance;
  logic [DATA_W-1:0] wdataShifted;

  logic [LANES-1:0]  bankWe;
  logic [WI_W-1:0]   bankAddr;
  logic [DATA_W-1:0] bankWdata;
  logic [DATA_W-1:0] bankRdata;

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keepMask;
  logic              signBit;
  logic [DATA_W-1:0] loadVal;
  int                keepBits;

  assign wordIdx      = req_addr[ADDR_W-1:LB];
  assign off          = req_addr[LB-1:0];
  assign offExt       = 3'(off);
  assign laneMask     = LANES'(lane_mask(req_size, offExt, LANES));
  assign reqErr       = is_misaligned(req_size, offExt, DATA_W);
  assign wdataShifted = req_wdata << (8 * off);

  // A new request may enter whenever the response slot is free or draining;
  // the request stage advances on exactly the same condition.
  assign advance   = !rsp_valid_q || rsp_ready;
  assign req_ready = init_done_q && advance;
  assign accept    = req_valid && req_ready;

  // Clear sweep, then run forever until the next reset.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_INIT;
      ic_q        <= '0;
      init_done_q <= 1'b0;
    end else begin
      if (state_q == ST_INIT) begin
        ic_q <= ic_q + 1'b1;
        if (ic_q == '1) begin
          state_q     <= ST_RUN;
          init_done_q <= 1'b1;
          ic_q        <= '0;
        end
      end
    end
  end

  // Bank port mux: the sweep owns all lanes during INIT, requests afterwards.
  always_comb begin
    bankWe    = '0;
    bankAddr  = wordIdx;
    bankWdata = wdataShifted;
    if (state_q == ST_INIT) begin
      bankWe    = '1;
      bankAddr  = ic_q;
      bankWdata = '0;
    end else if (accept && req_we && !reqErr) begin
      bankWe = laneMask;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dm_bank #(.AW(WI_W)) u_bank (
      .clk     (clk),
      .we_i    (bankWe[l]),
      .re_i    (accept),
      .addr_i  (bankAddr),
      .wdata_i (bankWdata[8*l +: 8]),
      .rdata_o (bankRdata[8*l +: 8])
    );
  end

  // Load extraction: align the addressed lanes to bit 0, keep 8<<size bits,
  // then sign- or zero-extend. Full-width accesses get an all-ones mask.
  always_comb begin
    shifted  = bankRdata >> (8 * pendOff_q);
    keepBits = 8 << pendSize_q;
    keepMask = (ONE << keepBits) - ONE;
    signBit  = |(shifted & ((ONE << keepBits) >> 1));
    loadVal  = (shifted & keepMask) | ((pendSigned_q && signBit) ? ~keepMask : '0);
  end

  // Next state of the request stage and the response register.
  always_comb begin
    pendValid_d  = pendValid_q;
    pendWe_d     = pendWe_q;
    pendErr_d    = pendErr_q;
    pendSize_d   = pendSize_q;
    pendSigned_d = pendSigned_q;
    pendOff_d    = pendOff_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    if (advance) begin
      pendValid_d = accept;
      if (accept) begin
        pendWe_d     = req_we;
        pendErr_d    = reqErr;
        pendSize_d   = req_size;
        pendSigned_d = req_signed;
        pendOff_d    = off;
      end
      rsp_valid_d = pendValid_q;
      rsp_rdata_d = (pendValid_q && !pendWe_q && !pendErr_q) ? loadVal : '0;
      rsp_err_d   = pendValid_q && pendErr_q;
    end
  end

  // Request stage and response register; reset drops anything in flight.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      pendValid_q  <= 1'b0;
      pendWe_q     <= 1'b0;
      pendErr_q    <= 1'b0;
      pendSize_q   <= DM_BYTE;
      pendSigned_q <= 1'b0;
      pendOff_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      pendValid_q  <= pendValid_d;
      pendWe_q     <= pendWe_d;
      pendErr_q    <= pendErr_d;
      pendSize_q   <= pendSize_d;
      pendSigned_q <= pendSigned_d;
      pendOff_q    <= pendOff_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign init_done = init_done_q;

endmodule
